// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED scan multiplexer and its formatting logic.
// Digit counts up to MAX_DIGITS are supported by the helper functions.
package led_pkg;

    localparam int          MAX_DIGITS     = 16;
    localparam logic [3:0]  LED_BLANK_CODE = 4'hF;

    // Values presented on the pins while in reset
    localparam logic        RST_DOT        = 1'b0;
    localparam logic        RST_FRAME_DONE = 1'b0;
    localparam logic [3:0]  RST_NIBBLE     = LED_BLANK_CODE;

    typedef logic [4*MAX_DIGITS-1:0] wide_data_t;
    typedef logic [MAX_DIGITS-1:0]   wide_sel_t;

    function automatic wide_sel_t onehot(input logic [3:0] idx, input int digits);
        wide_sel_t sel;
        sel = '0;
        if (int'(idx) < digits)
            sel[idx] = 1'b1;
        return sel;
    endfunction

    // Digit 0 lives in the most-significant nibble of a digits-wide word.
    function automatic logic [3:0] nibble(input wide_data_t data, input int digits,
                                          input logic [3:0] idx);
        wide_data_t shifted;
        shifted = data >> (4 * (digits - 1 - int'(idx)));
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/led_scan_tick.sv
// Slot prescaler for the LED scanner: counts SCAN_DIV cycles per digit slot,
// flags the last cycle of the slot and the lit window after the dead time.
module led_scan_tick #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic window
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // A zero dead time would make the compare trivially true, so it is not built.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign window = 1'b1;
        end else begin : g_blank
            assign window = (cnt >= CNT_W'(BLANK_CYCLES));
        end
    endgenerate

endmodule

// File: rtl/led_scan_mux.sv
// Self-scanning digit/dot multiplexer with dead time and frame-synchronous shadow data.
// Optional leading-zero suppression is built when LED_SCAN_LZS_EN is defined.
module led_scan_mux
    import led_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  enable_in,
    input  logic                  load_in,
    input  logic [4*DIGITS-1:0]   ledData_in,
    input  logic [DIGITS-1:0]     ledDot_in,
    output logic [DIGITS-1:0]     select_out,
    output logic [3:0]            ledDataSelected_out,
    output logic                  ledDotSelected_out,
    output logic                  frame_done_out
);

    localparam int IDX_W  = $clog2(DIGITS);
    localparam int DATA_W = 4 * DIGITS;

    generate
        if (DIGITS < 2 || DIGITS > MAX_DIGITS || SCAN_DIV < 2 ||
            BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_params
            $error("led_scan_mux: illegal DIGITS/SCAN_DIV/BLANK_CYCLES combination");
        end
    endgenerate

    logic              tick;
    logic              window;
    logic              wrap;
    logic              visible;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shadow_data;
    logic [DATA_W-1:0] pend_data;
    logic [DIGITS-1:0] shadow_dot;
    logic [DIGITS-1:0] pend_dot;
    logic              pend_v;
    logic [3:0]        raw_nibble;
    logic [3:0]        shown_nibble;
    logic [DIGITS-1:0] dot_shifted;
    wide_sel_t         sel_wide;

    led_scan_tick #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick (
        .clk    (clk_in),
        .rst_n  (rst_n_in),
        .tick   (tick),
        .window (window)
    );

    assign wrap    = tick && (idx == IDX_W'(DIGITS - 1));
    assign visible = enable_in && window;

    assign sel_wide    = onehot(4'(idx), DIGITS);
    assign raw_nibble  = nibble(wide_data_t'(shadow_data), DIGITS, 4'(idx));
    assign dot_shifted = shadow_dot >> (DIGITS - 1 - int'(idx));

`ifdef LED_SCAN_LZS_EN
    logic [DIGITS-1:0] lz_mask;
    logic              lead_zero;

    // NOTE: every variable driven here gets a default first so no path
    // through the block leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        lz_mask   = '0;
        lead_zero = 1'b1;
        for (int i = 0; i < DIGITS - 1; i++) begin
            lead_zero  = lead_zero &&
                         (nibble(wide_data_t'(shadow_data), DIGITS, 4'(i)) == 4'h0);
            lz_mask[i] = lead_zero;
        end
    end

    assign shown_nibble = lz_mask[idx] ? LED_BLANK_CODE : raw_nibble;
`else
    assign shown_nibble = raw_nibble;
`endif

    // NOTE: the shadow and pending registers are reset along with the control
    // state so a display that comes out of reset shows zeros, not stale data.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            idx                 <= '0;
            shadow_data         <= '0;
            shadow_dot          <= '0;
            pend_data           <= '0;
            pend_dot            <= '0;
            pend_v              <= 1'b0;
            select_out          <= '0;
            ledDataSelected_out <= RST_NIBBLE;
            ledDotSelected_out  <= RST_DOT;
            frame_done_out      <= RST_FRAME_DONE;
        end else begin
            if (tick)
                idx <= wrap ? '0 : idx + 1'b1;

            // A load coinciding with the wrap goes straight to the shadow copy.
            if (wrap) begin
                if (load_in) begin
                    shadow_data <= ledData_in;
                    shadow_dot  <= ledDot_in;
                end else if (pend_v) begin
                    shadow_data <= pend_data;
                    shadow_dot  <= pend_dot;
                end
                pend_v <= 1'b0;
            end else if (load_in) begin
                pend_data <= ledData_in;
                pend_dot  <= ledDot_in;
                pend_v    <= 1'b1;
            end

            if (visible) begin
                select_out          <= sel_wide[DIGITS-1:0];
                ledDataSelected_out <= shown_nibble;
                ledDotSelected_out  <= dot_shifted[0];
            end else begin
                select_out          <= '0;
                ledDataSelected_out <= LED_BLANK_CODE;
                ledDotSelected_out  <= 1'b0;
            end

            frame_done_out <= wrap;
        end
    end

endmodule

// File: tb/tb_led_scan_mux.sv
// Scoreboard bench for led_scan_mux: a cycle-time reference model predicts each
// output word, a monitor compares it one edge later.
module tb_led_scan_mux;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int BL = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          load;
    logic [15:0]   data;
    logic [3:0]    dot_in;
    logic [3:0]    select_out;
    logic [3:0]    data_out;
    logic          dot_out;
    logic          frame_done;

    always #5 clk = ~clk;

    led_scan_mux #(
        .DIGITS       (D),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk_in              (clk),
        .rst_n_in            (rst_n),
        .enable_in           (en),
        .load_in             (load),
        .ledData_in          (data),
        .ledDot_in           (dot_in),
        .select_out          (select_out),
        .ledDataSelected_out (data_out),
        .ledDotSelected_out  (dot_out),
        .frame_done_out      (frame_done)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] nib;
        logic       dot;
        logic       fd;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   started  = 1'b0;

    // Reference model: time since reset plus the frame's displayed and queued data
    int          t = 0;
    logic [15:0] shown_data = '0;
    logic [3:0]  shown_dot  = '0;
    logic [15:0] next_data  = '0;
    logic [3:0]  next_dot   = '0;
    bit          has_next   = 1'b0;

    function automatic obs_t predict(input logic en_v);
        obs_t e;
        int   phase = t % SD;
        int   slot  = (t / SD) % D;
        int   sh    = 4 * (D - 1 - slot);
        e.fd = (phase == SD - 1) && (slot == D - 1);
        if (en_v && phase >= BL) begin
            e.sel = 4'(1 << slot);
            e.nib = 4'(shown_data >> sh);
            e.dot = 1'(shown_dot >> (D - 1 - slot));
`ifdef LED_SCAN_LZS_EN
            if (slot < D - 1 && (shown_data >> sh) == 16'h0)
                e.nib = 4'hF;
`endif
        end else begin
            e.sel = 4'h0;
            e.nib = 4'hF;
            e.dot = 1'b0;
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic e_v, input logic l,
                        input logic [15:0] d, input logic [3:0] dt);
        obs_t e;
        @(negedge clk);
        rst_n  = r;
        en     = e_v;
        load   = l;
        data   = d;
        dot_in = dt;
        if (!r) begin
            e = '{4'h0, 4'hF, 1'b0, 1'b0};
            exp_q.push_back(e);
            t          = 0;
            shown_data = '0;
            shown_dot  = '0;
            has_next   = 1'b0;
        end else begin
            e = predict(e_v);
            exp_q.push_back(e);
            if (e.fd) begin
                if (l) begin
                    shown_data = d;
                    shown_dot  = dt;
                end else if (has_next) begin
                    shown_data = next_data;
                    shown_dot  = next_dot;
                end
                has_next = 1'b0;
            end else if (l) begin
                next_data = d;
                next_dot  = dt;
                has_next  = 1'b1;
            end
            t++;
        end
        started = 1'b1;
    endtask

    task automatic idle(input int n, input logic e_v);
        for (int i = 0; i < n; i++)
            step(1'b1, e_v, 1'b0, 16'h0, 4'h0);
    endtask

    // Advance until the next edge is the given slot/phase of the model's timeline.
    task automatic run_to(input int slot, input int phase);
        for (int k = 0; k < 4 * SD * D; k++) begin
            if ((t % SD) == phase && ((t / SD) % D) == slot)
                return;
            idle(1, 1'b1);
        end
        checks++;
        failures++;
        $display("FAIL run_to slot=%0d phase=%0d not reached, model t=%0d", slot, phase, t);
    endtask

    initial begin : monitor
        forever begin
            obs_t e;
            obs_t a;
            @(posedge clk);
            #1;
            if (started) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_underflow at %0t: no expected word queued", $time);
                end else begin
                    e = exp_q.pop_front();
                    a = '{select_out, data_out, dot_out, frame_done};
                    if (a !== e) begin
                        failures++;
                        $display("FAIL outputs at %0t: got sel=%b data=%h dot=%b fd=%b, want sel=%b data=%h dot=%b fd=%b",
                                 $time, a.sel, a.nib, a.dot, a.fd, e.sel, e.nib, e.dot, e.fd);
                    end
                end
            end
        end
    end

    initial begin : driver
        rst_n  = 1'b0;
        en     = 1'b1;
        load   = 1'b0;
        data   = '0;
        dot_in = '0;

        // Reset held for three cycles, then the zero frame from shadow reset
        repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

        // Load exactly at a frame wrap, visible in the frame that starts next
        run_to(D - 1, SD - 1);
        step(1'b1, 1'b1, 1'b1, 16'h1234, 4'b1000);
        idle(16, 1'b1);

        // Two mid-frame loads: latest wins, shown only after the wrap
        idle(5, 1'b1);
        step(1'b1, 1'b1, 1'b1, 16'hAAAA, 4'b0101);
        idle(3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 16'h5555, 4'b0000);
        idle(32, 1'b1);

        // Enable low for six cycles mid-frame; scan timing keeps running
        idle(3, 1'b1);
        idle(6, 1'b0);
        idle(20, 1'b1);

        // Reset while digit 2 is lit, then the shadow must read back as zero
        run_to(2, 3);
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        idle(20, 1'b1);

        // Leading-zero patterns (raw nibbles when suppression is not built)
        run_to(D - 1, SD - 1);
        step(1'b1, 1'b1, 1'b1, 16'h0070, 4'b0010);
        idle(16, 1'b1);
        run_to(D - 1, SD - 1);
        step(1'b1, 1'b1, 1'b1, 16'h0000, 4'b0001);
        idle(16, 1'b1);
        run_to(D - 1, SD - 1);
        step(1'b1, 1'b1, 1'b1, 16'h0F00, 4'b1111);
        idle(16, 1'b1);

        // Randomised traffic: sparse resets, enable drops, loads at any phase
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 199) != 0),
                 logic'($urandom_range(0, 7) != 0),
                 logic'($urandom_range(0, 9) == 0),
                 16'($urandom),
                 4'($urandom));
        end
        idle(2, 1'b1);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expected words left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
